// File: rtl/ahb_pkg.sv
// AHB-lite encodings and the address-phase bundle that is captured when a
// master loses arbitration for the shared SRAM port.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
  } ahb_addr_phase_t;

endpackage

// File: rtl/ahb_arb_hold.sv
// Per-port hold buffer: parks a losing address phase until it issues and
// presents either the parked or the live attributes to the arbiter.
module ahb_arb_hold
  import ahb_pkg::*;
(
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            req_live,
  input  logic            issue,
  input  ahb_addr_phase_t live_phase,
  output logic            hold_valid,
  output ahb_addr_phase_t phase
);

  logic            hold_valid_d, hold_valid_q;
  ahb_addr_phase_t held_d, held_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    held_d       = held_q;
    if (issue) begin
      hold_valid_d = 1'b0;
    end else if (req_live && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      held_d       = live_phase;
    end
  end

  // NOTE: state flops use non-blocking assignments only; the comb block above uses blocking.
  always_ff @(posedge HCLK) begin
    if (HRESET) hold_valid_q <= 1'b0;
    else        hold_valid_q <= hold_valid_d;
  end

  // NOTE: the parked payload is not reset; it is meaningless unless hold_valid_q is set.
  always_ff @(posedge HCLK) begin
    held_q <= held_d;
  end

  assign hold_valid = hold_valid_q;
  assign phase      = hold_valid_q ? held_q : live_phase;

endmodule

// File: rtl/ahb_sram_arb.sv
// Two-master AHB-lite arbiter in front of the single-ported SRAM slave:
// held-first / round-robin grant, data-phase owner tracking and routing.
module ahb_sram_arb
  import ahb_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [1:0]       HSEL_M,
  input  logic [1:0][31:0] HADDR_M,
  input  logic [1:0]       HWRITE_M,
  input  logic [1:0][2:0]  HSIZE_M,
  input  logic [1:0][2:0]  HBURST_M,
  input  logic [1:0][3:0]  HPROT_M,
  input  logic [1:0][1:0]  HTRANS_M,
  input  logic [1:0]       HREADY_M,
  input  logic [1:0][31:0] HWDATA_M,
  output logic [1:0]       HREADYOUT_M,
  output logic [1:0]       HRESP_M,
  output logic [1:0][31:0] HRDATA_M,
  output logic             S_HSEL,
  output logic [31:0]      S_HADDR,
  output logic             S_HWRITE,
  output logic [2:0]       S_HSIZE,
  output logic [2:0]       S_HBURST,
  output logic [3:0]       S_HPROT,
  output logic [1:0]       S_HTRANS,
  output logic [31:0]      S_HWDATA,
  output logic             S_HREADY,
  input  logic             S_HREADYOUT,
  input  logic             S_HRESP,
  input  logic [31:0]      S_HRDATA
);

  logic [1:0]      req_live, hold_valid, issue_port;
  ahb_addr_phase_t live_phase [2];
  ahb_addr_phase_t cand_phase [2];
  ahb_addr_phase_t win_phase;
  logic            any_cand, grant, issue, rr_pick;
  logic            owner_valid_d, owner_valid_q;
  logic            owner_id_d, owner_id_q;
  logic            last_grant_d, last_grant_q;
  logic            unused_htrans_lsb;

  // HTRANS[0] only separates BUSY from IDLE and SEQ from NONSEQ; neither matters here.
  assign unused_htrans_lsb = HTRANS_M[0][0] ^ HTRANS_M[1][0];

  for (genvar m = 0; m < 2; m++) begin : g_port
    logic is_owner;

    assign req_live[m]   = HSEL_M[m] & HTRANS_M[m][1] & HREADY_M[m];
    assign live_phase[m] = '{addr: HADDR_M[m], write: HWRITE_M[m], size: HSIZE_M[m],
                             burst: HBURST_M[m], prot: HPROT_M[m]};

    ahb_arb_hold u_hold (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .req_live   (req_live[m]),
      .issue      (issue_port[m]),
      .live_phase (live_phase[m]),
      .hold_valid (hold_valid[m]),
      .phase      (cand_phase[m])
    );

    assign is_owner       = owner_valid_q & (owner_id_q == 1'(m));
    assign HREADYOUT_M[m] = is_owner ? S_HREADYOUT : ~hold_valid[m];
    assign HRESP_M[m]     = is_owner ? S_HRESP : HRESP_OKAY;
    assign HRDATA_M[m]    = is_owner ? S_HRDATA : '0;
  end

  assign rr_pick = FIXED_PRI ? 1'b0 : ~last_grant_q;

  // Held requests always outrank live ones; ties within a class go to rr_pick.
  always_comb begin
    any_cand = 1'b0;
    grant    = 1'b0;
    if (|hold_valid) begin
      any_cand = 1'b1;
      grant    = (&hold_valid) ? rr_pick : hold_valid[1];
    end else if (|req_live) begin
      any_cand = 1'b1;
      grant    = (&req_live) ? rr_pick : req_live[1];
    end
    issue      = any_cand & S_HREADYOUT & ~HRESET;
    issue_port = issue ? (grant ? 2'b10 : 2'b01) : 2'b00;
    win_phase  = cand_phase[grant];
  end

  always_comb begin
    owner_valid_d = owner_valid_q;
    owner_id_d    = owner_id_q;
    last_grant_d  = last_grant_q;
    if (S_HREADYOUT) begin
      owner_valid_d = issue;
      owner_id_d    = grant;
    end
    if (issue) last_grant_d = grant;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_valid_q <= 1'b0;
      owner_id_q    <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      owner_valid_q <= owner_valid_d;
      owner_id_q    <= owner_id_d;
      last_grant_q  <= last_grant_d;
    end
  end

  always_comb begin
    S_HSEL   = issue;
    S_HTRANS = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    S_HADDR  = issue ? win_phase.addr  : '0;
    S_HWRITE = issue ? win_phase.write : 1'b0;
    S_HSIZE  = issue ? win_phase.size  : '0;
    S_HBURST = issue ? win_phase.burst : '0;
    S_HPROT  = issue ? win_phase.prot  : '0;
  end

  assign S_HREADY = S_HREADYOUT;
  assign S_HWDATA = owner_valid_q ? HWDATA_M[owner_id_q] : '0;

endmodule

// File: tb/tb_ahb_sram_arb.sv
// Bench for ahb_sram_arb: directed scenarios plus random traffic, all checked
// against a transaction-level model of the arbitration rules.
module tb_ahb_sram_arb;
  import ahb_pkg::*;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic             HRESET;
  logic [1:0]       HSEL_M, HWRITE_M, HREADY_M, HREADYOUT_M, HRESP_M;
  logic [1:0][31:0] HADDR_M, HWDATA_M, HRDATA_M;
  logic [1:0][2:0]  HSIZE_M, HBURST_M;
  logic [1:0][3:0]  HPROT_M;
  logic [1:0][1:0]  HTRANS_M;
  logic             S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT, S_HRESP;
  logic [31:0]      S_HADDR, S_HWDATA, S_HRDATA;
  logic [2:0]       S_HSIZE, S_HBURST;
  logic [3:0]       S_HPROT;
  logic [1:0]       S_HTRANS;

  logic [1:0]       f_hreadyout, f_hresp;
  logic [1:0][31:0] f_hrdata;
  logic             f_hsel, f_hwrite, f_hready;
  logic [31:0]      f_haddr, f_hwdata;
  logic [2:0]       f_hsize, f_hburst;
  logic [3:0]       f_hprot;
  logic [1:0]       f_htrans;

  ahb_sram_arb #(.FIXED_PRI(1'b0)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL_M(HSEL_M), .HADDR_M(HADDR_M), .HWRITE_M(HWRITE_M),
    .HSIZE_M(HSIZE_M), .HBURST_M(HBURST_M), .HPROT_M(HPROT_M), .HTRANS_M(HTRANS_M),
    .HREADY_M(HREADY_M), .HWDATA_M(HWDATA_M), .HREADYOUT_M(HREADYOUT_M), .HRESP_M(HRESP_M),
    .HRDATA_M(HRDATA_M), .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HTRANS(S_HTRANS),
    .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .S_HRDATA(S_HRDATA)
  );

  ahb_sram_arb #(.FIXED_PRI(1'b1)) u_fix (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL_M(HSEL_M), .HADDR_M(HADDR_M), .HWRITE_M(HWRITE_M),
    .HSIZE_M(HSIZE_M), .HBURST_M(HBURST_M), .HPROT_M(HPROT_M), .HTRANS_M(HTRANS_M),
    .HREADY_M(HREADY_M), .HWDATA_M(HWDATA_M), .HREADYOUT_M(f_hreadyout), .HRESP_M(f_hresp),
    .HRDATA_M(f_hrdata), .S_HSEL(f_hsel), .S_HADDR(f_haddr), .S_HWRITE(f_hwrite),
    .S_HSIZE(f_hsize), .S_HBURST(f_hburst), .S_HPROT(f_hprot), .S_HTRANS(f_htrans),
    .S_HWDATA(f_hwdata), .S_HREADY(f_hready), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .S_HRDATA(S_HRDATA)
  );

  // Reference model state (round-robin instance).
  bit              m_hv [2] = '{1'b0, 1'b0};
  ahb_addr_phase_t m_hold [2];
  int              m_last = 1;
  bit              m_own_v = 1'b0;
  int              m_own = 0;
  bit              e_fire;
  int              e_win;
  ahb_addr_phase_t e_ph;
  bit              e_live [2];
  int              n_tests = 0;
  int              n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ahb_addr_phase_t live_ph(input int m);
    return '{addr: HADDR_M[m], write: HWRITE_M[m], size: HSIZE_M[m],
             burst: HBURST_M[m], prot: HPROT_M[m]};
  endfunction

  function automatic bit pred_hready(input int m);
    if (m_own_v && m_own == m) return S_HREADYOUT;
    return !m_hv[m];
  endfunction

  // Rank each port: parked request 2, fresh request 1, nothing 0; ties alternate.
  task automatic predict();
    int score [2];
    for (int m = 0; m < 2; m++) begin
      e_live[m] = HSEL_M[m] && HREADY_M[m] &&
                  (HTRANS_M[m] == HTRANS_NONSEQ || HTRANS_M[m] == HTRANS_SEQ);
      score[m]  = m_hv[m] ? 2 : (e_live[m] ? 1 : 0);
    end
    e_win = -1;
    if (score[0] > score[1])      e_win = 0;
    else if (score[1] > score[0]) e_win = 1;
    else if (score[0] > 0)        e_win = 1 - m_last;
    e_fire = (e_win >= 0) && S_HREADYOUT && !HRESET;
    if (e_win >= 0) e_ph = m_hv[e_win] ? m_hold[e_win] : live_ph(e_win);
  endtask

  task automatic check_all();
    logic [1:0]       e_hro, e_resp;
    logic [1:0][31:0] e_rd;
    logic [31:0]      e_wd;
    bit               own;
    for (int m = 0; m < 2; m++) begin
      own       = m_own_v && (m_own == m);
      e_hro[m]  = pred_hready(m);
      e_resp[m] = own ? S_HRESP : HRESP_OKAY;
      e_rd[m]   = own ? S_HRDATA : 32'h0;
    end
    e_wd = m_own_v ? HWDATA_M[m_own] : 32'h0;
    check("s_sel_trans", {S_HSEL, S_HTRANS}, e_fire ? {1'b1, HTRANS_NONSEQ} : {1'b0, HTRANS_IDLE});
    if (e_fire) check("s_addr_phase", {S_HADDR, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT}, e_ph);
    check("s_hwdata", S_HWDATA, e_wd);
    check("hreadyout", HREADYOUT_M, e_hro);
    check("hresp", HRESP_M, e_resp);
    check("hrdata", HRDATA_M, e_rd);
    check("s_hready", S_HREADY, S_HREADYOUT);
  endtask

  // Drive the masters' bus HREADY, then sample mid-cycle and compare.
  task automatic eval();
    for (int m = 0; m < 2; m++) HREADY_M[m] = pred_hready(m);
    #4;
    predict();
    if (!HRESET) check_all();
  endtask

  task automatic tick();
    @(posedge HCLK);
    if (HRESET) begin
      m_hv    = '{1'b0, 1'b0};
      m_own_v = 1'b0;
      m_last  = 1;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (e_fire && e_win == m) m_hv[m] = 1'b0;
        else if (e_live[m] && !m_hv[m]) begin
          m_hv[m]   = 1'b1;
          m_hold[m] = live_ph(m);
        end
      end
      if (S_HREADYOUT) begin
        m_own_v = e_fire;
        m_own   = e_win;
      end
      if (e_fire) m_last = e_win;
    end
    #1;
  endtask

  task automatic idle_all();
    HSEL_M = '0; HTRANS_M = '0; HADDR_M = '0; HWRITE_M = '0; HSIZE_M = '0;
    HBURST_M = '0; HPROT_M = '0; HWDATA_M = '0;
    S_HREADYOUT = 1'b1; S_HRESP = HRESP_OKAY; S_HRDATA = '0;
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic w);
    HSEL_M[m] = 1'b1; HTRANS_M[m] = HTRANS_NONSEQ; HADDR_M[m] = a; HWRITE_M[m] = w;
    HSIZE_M[m] = HSIZE_WORD; HBURST_M[m] = HBURST_SINGLE; HPROT_M[m] = 4'b0011;
  endtask

  task automatic unreq(input int m);
    HSEL_M[m] = 1'b0; HTRANS_M[m] = HTRANS_IDLE;
  endtask

  task automatic do_reset();
    idle_all();
    HRESET = 1'b1;
    eval(); tick();
    eval(); tick();
    HRESET = 1'b0;
  endtask

  initial begin
    int k [2];
    int got [2];
    HREADY_M = 2'b11;
    do_reset();

    // Reset state.
    eval();
    check("rst_hreadyout", HREADYOUT_M, 2'b11);
    check("rst_strans", {S_HSEL, S_HTRANS, S_HWDATA}, {1'b0, HTRANS_IDLE, 32'h0});
    check("rst_resp_rdata", {HRESP_M, HRDATA_M}, '0);
    tick();

    // Uncontested M0 read.
    req(0, 32'h0000_0010, 1'b0);
    eval();
    check("t1_addr", S_HADDR, 32'h10);
    check("t1_hready0", HREADYOUT_M[0], 1'b1);
    tick();
    unreq(0); S_HRDATA = 32'h1234_5678;
    eval();
    check("t1_rdata", HRDATA_M[0], 32'h1234_5678);
    check("t1_hready0b", HREADYOUT_M[0], 1'b1);
    tick();

    // Simultaneous M0 write / M1 read: M1 pays exactly one wait.
    do_reset();
    req(0, 32'h20, 1'b1); req(1, 32'h24, 1'b0);
    eval();
    check("t2_first", {S_HADDR, S_HWRITE}, {32'h20, 1'b1});
    tick();
    unreq(0); unreq(1); HWDATA_M[0] = 32'hDEAD_0020;
    eval();
    check("t2_second", {S_HADDR, S_HWRITE}, {32'h24, 1'b0});
    check("t2_wdata", S_HWDATA, 32'hDEAD_0020);
    check("t2_m1_wait", HREADYOUT_M[1], 1'b0);
    tick();
    HWDATA_M[0] = '0; S_HRDATA = 32'h0000_0A24;
    eval();
    check("t2_m1_ready", HREADYOUT_M[1], 1'b1);
    check("t2_m1_rdata", HRDATA_M[1], 32'h0000_0A24);
    tick();
    S_HRDATA = '0;

    // Continuous contention for 8 cycles: strict alternation.
    do_reset();
    k = '{0, 0}; got = '{0, 0};
    for (int c = 0; c < 8; c++) begin
      req(0, 32'h1000 + 32'(4 * k[0]), 1'b0);
      req(1, 32'h2000 + 32'(4 * k[1]), 1'b0);
      eval();
      check("t3_grant", S_HADDR, ((c % 2) != 0 ? 32'h2000 : 32'h1000) + 32'(4 * (c / 2)));
      if (S_HTRANS == HTRANS_NONSEQ) got[(S_HADDR >= 32'h2000) ? 1 : 0]++;
      tick();
      for (int m = 0; m < 2; m++) if (HREADY_M[m]) k[m]++;
    end
    check("t3_m0_count", 64'(got[0]), 64'd4);
    check("t3_m1_count", 64'(got[1]), 64'd4);
    unreq(0); unreq(1);
    eval(); tick(); eval(); tick();

    // Fixed priority: M0 wins every live contest, round-robin alternates.
    do_reset();
    req(0, 32'h30, 1'b0);
    eval(); tick();
    req(0, 32'h34, 1'b0); req(1, 32'h38, 1'b0);
    eval();
    check("rr_live_contest", S_HADDR, 32'h38);
    check("fixed_live_contest", f_haddr, 32'h34);
    tick();
    unreq(0); unreq(1);
    eval();
    check("fixed_held_next", f_haddr, 32'h38);
    tick();
    eval(); tick();
    req(0, 32'h40, 1'b0); req(1, 32'h44, 1'b0);
    eval();
    check("rr_live_contest2", S_HADDR, 32'h44);
    check("fixed_live_contest2", f_haddr, 32'h40);
    tick();
    unreq(0); unreq(1);
    eval(); tick(); eval(); tick();

    // Downstream stall for 3 cycles with both ports requesting.
    do_reset();
    S_HREADYOUT = 1'b0;
    req(0, 32'h50, 1'b1); req(1, 32'h54, 1'b0);
    for (int c = 0; c < 3; c++) begin
      eval();
      check("t4_stall_idle", S_HTRANS, HTRANS_IDLE);
      if (c > 0) check("t4_holds", u_dut.hold_valid, 2'b11);
      tick();
    end
    S_HREADYOUT = 1'b1; unreq(0); unreq(1);
    eval();
    check("t4_rel0", S_HADDR, 32'h50);
    tick();
    eval();
    check("t4_rel1", S_HADDR, 32'h54);
    tick();
    eval(); tick();

    // Reset while M1's hold is valid.
    do_reset();
    req(0, 32'h60, 1'b0); req(1, 32'h64, 1'b0);
    eval(); tick();
    unreq(0); unreq(1); HRESET = 1'b1;
    eval(); tick();
    HRESET = 1'b0;
    eval();
    check("t5_hold_valid", u_dut.hold_valid, 2'b00);
    check("t5_hreadyout", HREADYOUT_M, 2'b11);
    check("t5_strans", S_HTRANS, HTRANS_IDLE);
    tick();

    // Error response during M1 data phase.
    do_reset();
    req(1, 32'h70, 1'b0);
    eval(); tick();
    unreq(1); S_HRESP = HRESP_ERROR;
    eval();
    check("t6_resp", HRESP_M, {HRESP_ERROR, HRESP_OKAY});
    tick();
    S_HRESP = HRESP_OKAY;

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        HSEL_M[m]   = ($urandom_range(0, 3) != 0);
        HTRANS_M[m] = 2'($urandom_range(0, 3));
        HADDR_M[m]  = $urandom;
        HWRITE_M[m] = 1'($urandom_range(0, 1));
        HSIZE_M[m]  = 3'($urandom_range(0, 2));
        HBURST_M[m] = 3'($urandom_range(0, 7));
        HPROT_M[m]  = 4'($urandom_range(0, 15));
        HWDATA_M[m] = $urandom;
      end
      S_HREADYOUT = ($urandom_range(0, 3) != 0);
      S_HRESP     = ($urandom_range(0, 7) == 0);
      S_HRDATA    = $urandom;
      eval();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
